alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Pipeline stage directly downstream of the 16-bit ALU; captures the ALU result, carry and zero with the destination register and condition code.
- Buffers entries in a 2-entry skid buffer with valid/ready handshakes on both sides.
- At commit, evaluates IITB-RISC conditional execution (ADC/ADZ/NDC/NDZ) against the architectural C/Z flags.
- Drives the register-file write port and owns the C and Z flag registers.

Parameters:
- DW, 16, data width of result and write data
- RW, 3, register-address width (8 GPRs)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_result  in  DW  ALU result
- in_carry  in  1  ALU carry out
- in_zero  in  1  ALU zero out
- in_rd  in  RW  destination register
- in_cond  in  2  00 always, 01 if C=1, 10 if Z=1, 11 never write (store/branch)
- in_fmask  in  2  [1] update C, [0] update Z
- flush  in  1  discard all buffered entries
- wb_valid  out  1  head entry presented
- wb_ready  in  1  consumer accepts head
- wb_en  out  1  head condition passed; register write enabled
- wb_addr  out  RW  head destination
- wb_data  out  DW  head result
- flag_c  out  1  architectural carry flag
- flag_z  out  1  architectural zero flag

Behaviour:
- Reset: occupancy EMPTY; flag_c=0, flag_z=0, wb_valid=0, wb_en=0, wb_addr=0, wb_data=0, in_ready=1.
- Occupancy FSM: EMPTY, ONE, FULL. Entry fields are {result, carry, zero, rd, cond, fmask}. The main register is the head; the skid register holds the second entry.
- Handshakes: accept = in_valid & in_ready; commit = wb_valid & wb_ready & !flush.
- in_ready is a registered signal, equal to (state != FULL). Upstream may hold in_valid high while in_ready=0; the data is then not captured.
- Latency: an entry accepted at edge N has wb_valid=1 from N+1.
- EMPTY: accept goes to main, next state ONE.
- ONE:
  - accept and commit together: main gets new data, stays ONE.
  - accept only: new data goes to skid, next state FULL.
  - commit only: next state EMPTY.
- FULL: no accept. Commit moves skid to main, next state ONE.
- Entries commit strictly in order. wb_data and wb_addr come from main and hold stable while wb_valid & !wb_ready.
- Condition evaluation at the head, combinational from flag_c/flag_z:
  - pass = (cond==00) | (cond==01 & flag_c) | (cond==10 & flag_z)
  - wb_en = wb_valid & pass
  - cond==11 never passes.
- Flags update only on commit with pass=1:
  - fmask[1]=1: flag_c ← carry.
  - fmask[0]=1: flag_z ← zero.
  - A failed condition or cond=11 is a no-op: flags unchanged, but the entry is still consumed.
- Because flags update at commit, back-to-back dependent conditionals see the flags of the immediately preceding committed instruction. No bypass is needed.
- Flush:
  - Next state EMPTY; any same-cycle accept is dropped.
  - wb_valid and wb_en are forced to 0 combinationally while flush=1; no commit occurs and flags are unchanged.
  - Flush has priority over all other events.
- Reset mid-operation: asynchronous clear of all state per the reset list above; buffered entries are lost.
- in_carry and in_zero are stored without modification. Width checks are the ALU's responsibility.

Decomposition:
- Shared package alu_wb_pkg: the cond encodings (COND_ALWAYS, COND_C, COND_Z, COND_NEVER), fmask bit indices, the FSM state enum, and a packed entry struct.
- One sub-module: wb_skid_buf. It is generic, parameterised by entry width, owns the FSM and in_ready, and is reusable for other stage boundaries.
- The top level adds condition evaluation and the flag registers.

Test Plan:
- Reset then a single entry {result=0x1234, rd=3, cond=00, fmask=11, carry=1, zero=0} with wb_ready=1 → wb_valid one cycle later; wb_en=1, addr=3, data=0x1234; after commit flag_c=1, flag_z=0.
- With flag_c=0, commit a cond=01 entry {carry=1} → wb_en=0, flag_c stays 0. Then a cond=00 entry with carry=1, followed back-to-back by cond=01 → the second entry has wb_en=1.
- wb_ready=0 with 3 entries offered → in_ready drops after 2 accepts, the third is held upstream. Release wb_ready → entries commit in order A, B, C with no loss or duplication, and wb_data is stable while stalled.
- Flush asserted while FULL, with in_valid=1 and wb_ready=1 → no commit, flags unchanged, next cycle wb_valid=0 and in_ready=1, and the offered entry is dropped.
- fmask=01 NAND entry {result=0, zero=1, carry=1}, cond=00 → flag_z=1 and flag_c unchanged. A cond=11 entry → wb_en=0 and flags unchanged.
- Assert reset_n low asynchronously while FULL, mid-cycle → outputs clear immediately without waiting for a clock edge; after release the stage is EMPTY with in_ready=1.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// Shared types for the ALU writeback stage: condition codes, flag-mask bits,
// the occupancy FSM state and the buffered entry layout.
package alu_wb_pkg;

   localparam int WB_DW = 16;
   localparam int WB_RW = 3;

   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_C      = 2'b01;
   localparam logic [1:0] COND_Z      = 2'b10;
   localparam logic [1:0] COND_NEVER  = 2'b11;

   localparam int FM_C = 1;
   localparam int FM_Z = 0;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   typedef struct packed {
      logic [WB_DW-1:0] result;
      logic             carry;
      logic             zero;
      logic [WB_RW-1:0] rd;
      logic [1:0]       cond;
      logic [1:0]       fmask;
   } wb_entry_t;

   function automatic logic cond_pass(input logic [1:0] cond, input logic c, input logic z);
      return (cond == COND_ALWAYS) | ((cond == COND_C) & c) | ((cond == COND_Z) & z);
   endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// ALU-to-writeback bundle: upstream entry handshake, flush, register-file
// write port and architectural flags.
interface alu_wb_if #(
   parameter int DW = 16,
   parameter int RW = 3
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_result;
   logic          in_carry;
   logic          in_zero;
   logic [RW-1:0] in_rd;
   logic [1:0]    in_cond;
   logic [1:0]    in_fmask;
   logic          flush;
   logic          wb_valid;
   logic          wb_ready;
   logic          wb_en;
   logic [RW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          flag_c;
   logic          flag_z;

   modport master (
      output in_valid, in_result, in_carry, in_zero, in_rd, in_cond, in_fmask,
      output flush, wb_ready,
      input  in_ready, wb_valid, wb_en, wb_addr, wb_data, flag_c, flag_z
   );

   modport slave (
      input  in_valid, in_result, in_carry, in_zero, in_rd, in_cond, in_fmask,
      input  flush, wb_ready,
      output in_ready, wb_valid, wb_en, wb_addr, wb_data, flag_c, flag_z
   );
endinterface

// File: rtl/alu_wb_stage_skid_buf.sv
// Generic 2-entry skid buffer: head visible one cycle after accept; in_ready is
// registered and drops only when both entries are held; flush empties it.
module wb_skid_buf
   import alu_wb_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   occ_t         state;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         accept;
   logic         commit;

   assign accept   = in_valid & in_ready;
   assign commit   = out_valid & out_ready & ~flush;
   assign out_data = main_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= OCC_EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else if (flush) begin
         state     <= OCC_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            OCC_EMPTY: begin
               if (accept) begin
                  main_q    <= in_data;
                  state     <= OCC_ONE;
                  out_valid <= 1'b1;
               end
            end
            OCC_ONE: begin
               if (accept && commit) begin
                  main_q <= in_data;
               end else if (accept) begin
                  skid_q   <= in_data;
                  state    <= OCC_FULL;
                  in_ready <= 1'b0;
               end else if (commit) begin
                  state     <= OCC_EMPTY;
                  out_valid <= 1'b0;
               end
            end
            OCC_FULL: begin
               // in_ready is low here, so the only event is draining the head
               if (commit) begin
                  main_q   <= skid_q;
                  state    <= OCC_ONE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= OCC_EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: skid-buffered entries, conditional register write and C/Z flags.
// Latency 1 cycle accept-to-head; backpressure via wb_ready, in_ready drops when full.
module alu_wb_stage
   import alu_wb_pkg::*;
#(
   parameter int DW = WB_DW,
   parameter int RW = WB_RW
) (
   input logic   clk,
   input logic   reset_n,
   alu_wb_if.slave bus
);
   wb_entry_t                     in_ent;
   wb_entry_t                     head;
   logic [$bits(wb_entry_t)-1:0]  head_raw;
   logic                          buf_valid;
   logic                          pass;
   logic                          commit;
   logic                          flag_c_q;
   logic                          flag_z_q;
   logic [DW-1:0]                 head_result;
   logic [RW-1:0]                 head_rd;

   always_comb begin
      in_ent        = '0;
      in_ent.result = bus.in_result;
      in_ent.carry  = bus.in_carry;
      in_ent.zero   = bus.in_zero;
      in_ent.rd     = bus.in_rd;
      in_ent.cond   = bus.in_cond;
      in_ent.fmask  = bus.in_fmask;
   end

   wb_skid_buf #(
      .W($bits(wb_entry_t))
   ) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (bus.flush),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (in_ent),
      .out_valid (buf_valid),
      .out_ready (bus.wb_ready),
      .out_data  (head_raw)
   );

   assign head        = head_raw;
   assign head_result = head.result;
   assign head_rd     = head.rd;

   // Condition sees the flags left by the previous commit, so no bypass is needed.
   assign pass   = cond_pass(head.cond, flag_c_q, flag_z_q);
   assign commit = bus.wb_valid & bus.wb_ready;

   assign bus.wb_valid = buf_valid & ~bus.flush;
   assign bus.wb_en    = bus.wb_valid & pass;
   assign bus.wb_addr  = head_rd;
   assign bus.wb_data  = head_result;
   assign bus.flag_c   = flag_c_q;
   assign bus.flag_z   = flag_z_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag_c_q <= 1'b0;
         flag_z_q <= 1'b0;
      end else if (commit && pass) begin
         if (head.fmask[FM_C]) flag_c_q <= head.carry;
         if (head.fmask[FM_Z]) flag_z_q <= head.zero;
      end
   end
endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: directed entries with hand-computed write
// enables and post-commit flags, checked by an independent monitor.
module tb_alu_wb_stage;
   typedef struct {
      logic        en;
      logic [2:0]  addr;
      logic [15:0] data;
      logic        c;
      logic        z;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   exp_t q[$];
   logic pend = 1'b0;
   logic pend_c, pend_z;

   alu_wb_if #(.DW(16), .RW(3)) bus ();

   alu_wb_stage dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the presented head against the scoreboard front every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            q.delete();
            pend = 1'b0;
         end else begin
            if (pend) begin
               chk("flag_c_after_commit", {31'd0, bus.flag_c}, {31'd0, pend_c});
               chk("flag_z_after_commit", {31'd0, bus.flag_z}, {31'd0, pend_z});
               pend = 1'b0;
            end
            if (bus.flush) begin
               q.delete();
            end else if (bus.wb_valid) begin
               if (q.size() == 0) begin
                  chk("unexpected_wb_valid", 32'd1, 32'd0);
               end else begin
                  chk("wb_en",   {31'd0, bus.wb_en},   {31'd0, q[0].en});
                  chk("wb_addr", {29'd0, bus.wb_addr}, {29'd0, q[0].addr});
                  chk("wb_data", {16'd0, bus.wb_data}, {16'd0, q[0].data});
                  if (bus.wb_ready) begin
                     pend_c = q[0].c;
                     pend_z = q[0].z;
                     pend   = 1'b1;
                     void'(q.pop_front());
                  end
               end
            end
         end
      end
   end

   task automatic drive(input logic [15:0] res, input logic c, input logic z,
                        input logic [2:0] rd, input logic [1:0] cond, input logic [1:0] fm);
      bus.in_valid  = 1'b1;
      bus.in_result = res;
      bus.in_carry  = c;
      bus.in_zero   = z;
      bus.in_rd     = rd;
      bus.in_cond   = cond;
      bus.in_fmask  = fm;
   endtask

   // Waits for the handshake, then records the expectation after the accepting edge.
   task automatic wait_acc(input logic xen, input logic [2:0] rd, input logic [15:0] res,
                           input logic xc, input logic xz);
      exp_t e;
      bit   ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      if (ok) begin
         e.en = xen; e.addr = rd; e.data = res; e.c = xc; e.z = xz;
         q.push_back(e);
      end
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic send(input logic [15:0] res, input logic c, input logic z,
                       input logic [2:0] rd, input logic [1:0] cond, input logic [1:0] fm,
                       input logic xen, input logic xc, input logic xz);
      drive(res, c, z, rd, cond, fm);
      wait_acc(xen, rd, res, xc, xz);
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !pend) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_result = '0; bus.in_carry = 1'b0; bus.in_zero = 1'b0;
      bus.in_rd = '0; bus.in_cond = '0; bus.in_fmask = '0; bus.flush = 1'b0; bus.wb_ready = 1'b1;

      // Reset values
      #12;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      chk("rst_wb_en",    {31'd0, bus.wb_en},    32'd0);
      chk("rst_wb_addr",  {29'd0, bus.wb_addr},  32'd0);
      chk("rst_wb_data",  {16'd0, bus.wb_data},  32'd0);
      chk("rst_flag_c",   {31'd0, bus.flag_c},   32'd0);
      chk("rst_flag_z",   {31'd0, bus.flag_z},   32'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(posedge clk); #1;

      // Single entry, then valid one cycle after accept
      drive(16'h1234, 1'b1, 1'b0, 3'd3, 2'b00, 2'b11);
      wait_acc(1'b1, 3'd3, 16'h1234, 1'b1, 1'b0);
      @(negedge clk);
      chk("latency_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      drain();

      // Conditional on C with C=0, then dependent back-to-back conditional
      send(16'h0000, 1'b0, 1'b0, 3'd1, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
      send(16'h00AA, 1'b1, 1'b0, 3'd2, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
      send(16'h0055, 1'b1, 1'b1, 3'd4, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0);
      send(16'h0077, 1'b0, 1'b0, 3'd5, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
      drain();

      // Backpressure: two accepts fill, third held upstream
      bus.wb_ready = 1'b0;
      send(16'h1111, 1'b0, 1'b0, 3'd1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
      send(16'h2222, 1'b0, 1'b0, 3'd2, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
      drive(16'h3333, 1'b0, 1'b0, 3'd3, 2'b00, 2'b00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      @(posedge clk); #1 bus.wb_ready = 1'b1;
      wait_acc(1'b1, 3'd3, 16'h3333, 1'b1, 1'b0);
      drain();

      // Flush while full with a same-cycle offer
      bus.wb_ready = 1'b0;
      send(16'h4444, 1'b0, 1'b1, 3'd6, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1);
      send(16'h5555, 1'b0, 1'b1, 3'd7, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1);
      drive(16'h6666, 1'b0, 1'b1, 3'd2, 2'b00, 2'b11);
      bus.wb_ready = 1'b1;
      bus.flush    = 1'b1;
      @(negedge clk);
      chk("flush_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      chk("flush_wb_en",    {31'd0, bus.wb_en},    32'd0);
      @(posedge clk); #1 bus.flush = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      chk("post_flush_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      chk("post_flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("post_flush_flag_c",   {31'd0, bus.flag_c},   32'd1);
      chk("post_flush_flag_z",   {31'd0, bus.flag_z},   32'd0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;

      // Z-only update, never-write, and Z-conditional
      send(16'h0001, 1'b0, 1'b0, 3'd1, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
      send(16'h0000, 1'b1, 1'b1, 3'd7, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1);
      send(16'h9999, 1'b1, 1'b0, 3'd2, 2'b11, 2'b11, 1'b0, 1'b0, 1'b1);
      send(16'h0ABC, 1'b1, 1'b0, 3'd3, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1);
      drain();

      // Asynchronous reset while full, between clock edges
      bus.wb_ready = 1'b0;
      send(16'h6666, 1'b1, 1'b1, 3'd1, 2'b00, 2'b11, 1'b1, 1'b1, 1'b1);
      send(16'h7777, 1'b1, 1'b1, 3'd2, 2'b00, 2'b11, 1'b1, 1'b1, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      chk("arst_wb_addr",  {29'd0, bus.wb_addr},  32'd0);
      chk("arst_wb_data",  {16'd0, bus.wb_data},  32'd0);
      chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("arst_flag_z",   {31'd0, bus.flag_z},   32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("post_arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("post_arst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      @(posedge clk); #1 bus.wb_ready = 1'b1;
      send(16'h00FF, 1'b1, 1'b0, 3'd2, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
